// File: rtl/part_event_arbiter.sv
// part_event_arbiter: round-robin arbiter feeding a registered x/y/range-class unit.
// Define PART_BIN_COUNT_EN to build the per-bin saturating event counters.
module part_event_arbiter #(
   parameter int NREQ = 4,
   parameter int W = 3,
   localparam int IDW = $clog2(NREQ)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [NREQ-1:0]   req_valid,
   output logic [NREQ-1:0]   req_ready,
   input  logic [NREQ*W-1:0] req_a,
   input  logic [NREQ*W-1:0] req_b,
   input  logic [NREQ*W-1:0] req_c,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [W-1:0]      out_x,
   output logic [W-1:0]      out_y,
   output logic [1:0]        out_bin,
   output logic [IDW-1:0]    out_id,
   output logic [31:0]       bin_count
);
   localparam logic EMPTY = 1'b0;
   localparam logic FULL  = 1'b1;
   logic           state_q, state_d;
   logic [IDW-1:0] ptr_q, ptr_d, gnt, scan, id_q, id_d;
   logic           hit, can_accept;
   logic [W-1:0]   a_s, b_s, c_s, x_q, x_d, y_q, y_d;
   logic [1:0]     bin_s, bin_q, bin_d;
   always_comb begin
      can_accept = !rst && (state_q == EMPTY || out_ready);
      hit = 1'b0;
      gnt = '0;
      scan = '0;
      req_ready = '0;
      for (int k = 0; k < NREQ; k++) begin
         scan = IDW'((int'(ptr_q) + k) % NREQ);
         if (!hit && can_accept && req_valid[scan]) begin
            hit = 1'b1;
            gnt = scan;
         end
      end
      if (hit) req_ready[gnt] = 1'b1;
   end
   always_comb begin
      a_s = req_a[int'(gnt)*W +: W];
      b_s = req_b[int'(gnt)*W +: W];
      c_s = req_c[int'(gnt)*W +: W];
      bin_s = (a_s == '0) ? 2'd0 : (&a_s) ? 2'd3 : a_s[W-1] ? 2'd2 : 2'd1;
      state_d = hit ? FULL : out_ready ? EMPTY : state_q;
      ptr_d = hit ? ((int'(gnt) == NREQ-1) ? '0 : gnt + 1'b1) : ptr_q;
      x_d = hit ? (a_s & b_s) : x_q;
      y_d = hit ? ((b_s | c_s) ^ a_s) : y_q;
      bin_d = hit ? bin_s : bin_q;
      id_d = hit ? gnt : id_q;
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= EMPTY;
         ptr_q <= '0;
         x_q <= '0;
         y_q <= '0;
         bin_q <= '0;
         id_q <= '0;
      end else begin
         state_q <= state_d;
         ptr_q <= ptr_d;
         x_q <= x_d;
         y_q <= y_d;
         bin_q <= bin_d;
         id_q <= id_d;
      end
   end
   assign out_valid = state_q;
   assign out_x = x_q;
   assign out_y = y_q;
   assign out_bin = bin_q;
   assign out_id = id_q;
`ifdef PART_BIN_COUNT_EN
   logic [7:0] cnt_q [4];
   logic [7:0] cnt_d [4];
   always_comb begin
      for (int k = 0; k < 4; k++)
         cnt_d[k] = (hit && bin_s == 2'(k) && cnt_q[k] != 8'hff) ? cnt_q[k] + 8'd1 : cnt_q[k];
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int k = 0; k < 4; k++) cnt_q[k] <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end
   assign bin_count = {cnt_q[3], cnt_q[2], cnt_q[1], cnt_q[0]};
`else
   assign bin_count = '0;
`endif
endmodule

// File: tb/tb_part_event_arbiter.sv
// tb_part_event_arbiter: vector table plus scoreboard check of part_event_arbiter.
module tb_part_event_arbiter;
   localparam int NREQ = 4;
   localparam int W = 3;
   typedef struct packed {
      logic [2:0] x;
      logic [2:0] y;
      logic [1:0] bin;
      logic [1:0] id;
   } exp_t;
   typedef struct {
      int         id;
      logic [2:0] a;
      logic [2:0] b;
      logic [2:0] c;
      exp_t       e;
   } vec_t;
   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [3:0]  req_valid = '0;
   logic [3:0]  req_ready;
   logic [11:0] req_a = '0, req_b = '0, req_c = '0;
   logic        out_valid;
   logic        out_ready = 1'b1;
   logic [2:0]  out_x, out_y;
   logic [1:0]  out_bin, out_id;
   logic [31:0] bin_count;
   int          checks = 0, passes = 0;
   int          mptr = 0;
   logic        mvalid = 1'b0;
   logic [7:0]  mcnt [4] = '{default: '0};
   exp_t        sb [$];
   exp_t        last = '0;
   exp_t        none = '0;
   vec_t        tbl [8];
   int          rr_seq [6] = '{0, 1, 2, 3, 0, 1};

   part_event_arbiter #(.NREQ(NREQ), .W(W)) dut (
      .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
      .req_a(req_a), .req_b(req_b), .req_c(req_c),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_x(out_x), .out_y(out_y), .out_bin(out_bin), .out_id(out_id),
      .bin_count(bin_count)
   );

   always #5 clk = ~clk;

   task automatic chk(input string n, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got === exp) passes++;
      else $display("FAIL %s: got %0h expected %0h", n, got, exp);
   endtask

   function automatic exp_t model(input int g);
      exp_t r;
      logic [2:0] a, b, c;
      a = req_a[g*3 +: 3];
      b = req_b[g*3 +: 3];
      c = req_c[g*3 +: 3];
      r.x = a & b;
      r.y = (b | c) ^ a;
      r.bin = (a == 0) ? 2'd0 : (a == 7) ? 2'd3 : (a >= 4) ? 2'd2 : 2'd1;
      r.id = 2'(g);
      return r;
   endfunction

   task automatic set_req(input int id, input logic [2:0] a, input logic [2:0] b, input logic [2:0] c);
      req_a[id*3 +: 3] = a;
      req_b[id*3 +: 3] = b;
      req_c[id*3 +: 3] = c;
   endtask

   task automatic step(input logic ordy, input bit has_exp, input exp_t e);
      logic [3:0] exp_rdy;
      bit hit;
      int g, idx;
      exp_t r;
      out_ready = ordy;
      @(negedge clk);
      exp_rdy = '0;
      hit = 0;
      g = 0;
      for (int k = 0; k < NREQ; k++) begin
         idx = (mptr + k) % NREQ;
         if (!hit && (!mvalid || ordy) && req_valid[idx]) begin
            hit = 1;
            g = idx;
         end
      end
      if (hit) begin
         exp_rdy[g] = 1'b1;
         sb.push_back(has_exp ? e : model(g));
      end
      chk("req_ready", 32'(req_ready), 32'(exp_rdy));
      @(posedge clk);
      #1;
      if (hit) mptr = (g + 1) % NREQ;
      mvalid = hit ? 1'b1 : ordy ? 1'b0 : mvalid;
      chk("out_valid", 32'(out_valid), 32'(mvalid));
      if (hit) begin
         if (sb.size() == 0) begin
            chk("scoreboard_empty", 32'(1), 32'(0));
         end else begin
            r = sb.pop_front();
            last = r;
`ifdef PART_BIN_COUNT_EN
            if (mcnt[r.bin] != 8'hff) mcnt[r.bin] = mcnt[r.bin] + 8'd1;
`endif
         end
      end
      if (mvalid) begin
         chk("out_x", 32'(out_x), 32'(last.x));
         chk("out_y", 32'(out_y), 32'(last.y));
         chk("out_bin", 32'(out_bin), 32'(last.bin));
         chk("out_id", 32'(out_id), 32'(last.id));
      end
      chk("bin_count", bin_count, {mcnt[3], mcnt[2], mcnt[1], mcnt[0]});
   endtask

   task automatic do_reset();
      rst = 1'b1;
      out_ready = 1'b1;
      @(negedge clk);
      chk("ready_in_rst", 32'(req_ready), 32'(0));
      @(posedge clk);
      #1;
      rst = 1'b0;
      mptr = 0;
      mvalid = 1'b0;
      sb.delete();
      for (int k = 0; k < 4; k++) mcnt[k] = '0;
      chk("rst_out_valid", 32'(out_valid), 32'(0));
      chk("rst_outputs", {22'd0, out_x, out_y, out_bin, out_id}, 32'(0));
      chk("rst_bin_count", bin_count, 32'(0));
   endtask

   initial begin
      tbl[0] = '{2, 3'b101, 3'b011, 3'b100, '{3'b001, 3'b010, 2'd2, 2'd2}};
      tbl[1] = '{0, 3'b000, 3'b111, 3'b000, '{3'b000, 3'b111, 2'd0, 2'd0}};
      tbl[2] = '{1, 3'b111, 3'b010, 3'b001, '{3'b010, 3'b100, 2'd3, 2'd1}};
      tbl[3] = '{3, 3'b011, 3'b100, 3'b010, '{3'b000, 3'b101, 2'd1, 2'd3}};
      tbl[4] = '{1, 3'b100, 3'b100, 3'b000, '{3'b100, 3'b000, 2'd2, 2'd1}};
      tbl[5] = '{3, 3'b001, 3'b001, 3'b110, '{3'b001, 3'b110, 2'd1, 2'd3}};
      tbl[6] = '{0, 3'b110, 3'b101, 3'b011, '{3'b100, 3'b001, 2'd2, 2'd0}};
      tbl[7] = '{2, 3'b010, 3'b000, 3'b000, '{3'b000, 3'b010, 2'd1, 2'd2}};
      do_reset();
      for (int i = 0; i < 5; i++) begin
         step(1'b1, 0, none);
         chk("idle_outputs", {22'd0, out_x, out_y, out_bin, out_id}, 32'(0));
      end
      for (int i = 0; i < 8; i++) begin
         req_valid = '0;
         set_req(tbl[i].id, tbl[i].a, tbl[i].b, tbl[i].c);
         req_valid[tbl[i].id] = 1'b1;
         step(1'b1, 1, tbl[i].e);
      end
      req_valid = '0;
      step(1'b1, 0, none);
      do_reset();
      req_a = 12'($urandom);
      req_b = 12'($urandom);
      req_c = 12'($urandom);
      req_valid = 4'b1111;
      for (int i = 0; i < 6; i++) begin
         step(1'b1, 0, none);
         chk("rr_id", 32'(out_id), 32'(rr_seq[i]));
      end
      for (int i = 0; i < 4; i++) step(1'b0, 0, none);
      step(1'b1, 0, none);
      chk("drain_accept_valid", 32'(out_valid), 32'(1));
      step(1'b0, 0, none);
      req_valid = 4'b1010;
      do_reset();
      step(1'b1, 0, none);
      chk("post_rst_grant", 32'(out_id), 32'(1));
      for (int i = 0; i < 200; i++) begin
         req_valid = 4'($urandom);
         req_a = 12'($urandom);
         req_b = 12'($urandom);
         req_c = 12'($urandom);
         step(1'($urandom_range(0, 1)), 0, none);
      end
      do_reset();
      req_valid = 4'b0001;
      set_req(0, 3'b111, 3'b000, 3'b000);
      for (int i = 0; i < 300; i++) step(1'b1, 0, none);
`ifdef PART_BIN_COUNT_EN
      chk("bin3_saturated", 32'(bin_count[31:24]), 32'(255));
      chk("bins_0_2_zero", 32'(bin_count[23:0]), 32'(0));
`else
      chk("bin_count_tied", bin_count, 32'(0));
`endif
      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end
endmodule
